// File: rtl/axi4_lite_write_slave_if.sv
// ---------------------------------------------------------------------------
// axi4_lite_write_slave_if
// Bundles the AXI4-Lite write-side channels (AW, W, B) into one interface.
//
// Signals:
//   awaddr/awvalid/awready : write address channel
//   wdata/wstrb/wvalid/wready : write data channel (wstrb = one bit per byte)
//   bresp/bvalid/bready : write response channel (2'b00 OKAY, 2'b10 SLVERR)
//
// Modports:
//   master : drives AW/W payload and valids plus bready
//   slave  : drives awready, wready, bresp, bvalid
// ---------------------------------------------------------------------------
interface axi4_lite_write_slave_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/axi4_lite_write_slave.sv
// ---------------------------------------------------------------------------
// axi4_lite_write_slave
// AXI4-Lite write endpoint. Collects AW and W independently (either order or
// together), range-checks the address against [BASE_ADDR, BASE_ADDR+SIZE_BYTES)
// and issues one single-cycle write on a simple memory port, then returns a
// B response. Only one write is ever outstanding.
//
// Ports:
//   clk       : clock, all flops rise-edge
//   rst       : asynchronous reset, active low
//   s_axi     : AXI4-Lite write channels (slave modport)
//   mem_we    : one-cycle write enable (only for in-window addresses)
//   mem_addr  : word-aligned byte offset into the window
//   mem_wdata : captured write data
//   mem_wstrb : captured byte strobes
// ---------------------------------------------------------------------------
module axi4_lite_write_slave #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter logic [ADDR_WIDTH-1:0] SIZE_BYTES = ADDR_WIDTH'(32'h0000_4000),
   localparam int                   STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   axi4_lite_write_slave_if.slave s_axi,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [STRB_WIDTH-1:0] mem_wstrb
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

   typedef enum logic [1:0] {
      COLLECT,
      WRITE,
      RESP
   } state_t;

   state_t                state, state_next;
   logic                  aw_full, aw_full_next;
   logic                  w_full, w_full_next;
   logic [ADDR_WIDTH-1:0] addr_q, addr_next;
   logic [DATA_WIDTH-1:0] data_q, data_next;
   logic [STRB_WIDTH-1:0] strb_q, strb_next;
   logic                  hit_q, hit_next;
   logic                  awready_q, awready_next;
   logic                  wready_q, wready_next;
   logic                  bvalid_q, bvalid_next;
   logic [1:0]            bresp_q, bresp_next;
   logic                  mem_we_next;
   logic [ADDR_WIDTH-1:0] mem_addr_next;
   logic [DATA_WIDTH-1:0] mem_wdata_next;
   logic [STRB_WIDTH-1:0] mem_wstrb_next;

   logic                  aw_hs;
   logic                  w_hs;
   logic [ADDR_WIDTH-1:0] cand_addr;
   logic [ADDR_WIDTH-1:0] cand_off;
   logic [ADDR_WIDTH:0]   window_end;
   logic                  cand_hit;

   // Handshakes use the registered readies, which are only ever high in
   // COLLECT, so nothing can be captured while a write is outstanding.
   assign aw_hs = s_axi.awvalid && awready_q;
   assign w_hs  = s_axi.wvalid  && wready_q;

   // The address that will be decoded if the transaction completes this edge:
   // the live AWADDR when AW is accepted now, otherwise the earlier capture.
   // The window end is one bit wider so BASE_ADDR+SIZE_BYTES can reach the
   // top of the address space without wrapping to zero.
   assign cand_addr  = aw_hs ? s_axi.awaddr : addr_q;
   assign window_end = {1'b0, BASE_ADDR} + {1'b0, SIZE_BYTES};
   assign cand_hit   = ({1'b0, cand_addr} >= {1'b0, BASE_ADDR}) &&
                       ({1'b0, cand_addr} <  window_end);
   assign cand_off   = (cand_addr - BASE_ADDR) & WORD_MASK;

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;

   // State and output register bank. Every output is registered so the
   // memory port and AXI handshakes are glitch-free; reset clears all of
   // them at once, which also discards any half-finished transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= COLLECT;
         aw_full   <= 1'b0;
         w_full    <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
         hit_q     <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else begin
         state     <= state_next;
         aw_full   <= aw_full_next;
         w_full    <= w_full_next;
         addr_q    <= addr_next;
         data_q    <= data_next;
         strb_q    <= strb_next;
         hit_q     <= hit_next;
         awready_q <= awready_next;
         wready_q  <= wready_next;
         bvalid_q  <= bvalid_next;
         bresp_q   <= bresp_next;
         mem_we    <= mem_we_next;
         mem_addr  <= mem_addr_next;
         mem_wdata <= mem_wdata_next;
         mem_wstrb <= mem_wstrb_next;
      end
   end

   // Next-state and next-output logic. The memory write is launched on the
   // same edge that completes the AW/W pair so mem_we is high for exactly the
   // WRITE cycle; the response is latched from the decode on the next edge.
   // Readies are computed one edge ahead, so they drop on the capture edge
   // and rise again on the B handshake edge.
   always_comb begin
      state_next     = state;
      aw_full_next   = aw_full;
      w_full_next    = w_full;
      addr_next      = addr_q;
      data_next      = data_q;
      strb_next      = strb_q;
      hit_next       = hit_q;
      awready_next   = 1'b0;
      wready_next    = 1'b0;
      bvalid_next    = bvalid_q;
      bresp_next     = bresp_q;
      mem_we_next    = 1'b0;
      mem_addr_next  = mem_addr;
      mem_wdata_next = mem_wdata;
      mem_wstrb_next = mem_wstrb;

      case (state)
         COLLECT: begin
            if (aw_hs) begin
               addr_next    = s_axi.awaddr;
               aw_full_next = 1'b1;
            end
            if (w_hs) begin
               data_next   = s_axi.wdata;
               strb_next   = s_axi.wstrb;
               w_full_next = 1'b1;
            end
            if (aw_full_next && w_full_next) begin
               state_next     = WRITE;
               hit_next       = cand_hit;
               mem_we_next    = cand_hit;
               mem_addr_next  = cand_off;
               mem_wdata_next = data_next;
               mem_wstrb_next = strb_next;
            end else begin
               awready_next = !aw_full_next;
               wready_next  = !w_full_next;
            end
         end

         WRITE: begin
            state_next  = RESP;
            bvalid_next = 1'b1;
            bresp_next  = hit_q ? RESP_OKAY : RESP_SLVERR;
         end

         RESP: begin
            if (s_axi.bready) begin
               state_next   = COLLECT;
               bvalid_next  = 1'b0;
               aw_full_next = 1'b0;
               w_full_next  = 1'b0;
               awready_next = 1'b1;
               wready_next  = 1'b1;
            end
         end

         default: begin
            state_next = COLLECT;
         end
      endcase
   end

endmodule

// File: tb/tb_axi4_lite_write_slave.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_write_slave
// Drives two slaves in lockstep from the same AXI stimulus: one decoding the
// default low window, one decoding the last 4 KiB of the address space. The
// expected responses come from a simple window/offset model of each slave.
// ---------------------------------------------------------------------------
module tb_axi4_lite_write_slave;

   localparam logic [31:0] BASE0 = 32'h0000_0000;
   localparam logic [31:0] SIZE0 = 32'h0000_4000;
   localparam logic [31:0] BASE1 = 32'hFFFF_F000;
   localparam logic [31:0] SIZE1 = 32'h0000_1000;

   logic        clk;
   logic        rst;
   logic [31:0] awaddr;
   logic        awvalid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        bready;

   logic        mem_we0,   mem_we1;
   logic [31:0] mem_addr0, mem_addr1;
   logic [31:0] mem_wdata0, mem_wdata1;
   logic [3:0]  mem_wstrb0, mem_wstrb1;

   int checkCount = 0;
   int errorCount = 0;

   axi4_lite_write_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
   axi4_lite_write_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

   assign bus0.awaddr  = awaddr;
   assign bus0.awvalid = awvalid;
   assign bus0.wdata   = wdata;
   assign bus0.wstrb   = wstrb;
   assign bus0.wvalid  = wvalid;
   assign bus0.bready  = bready;
   assign bus1.awaddr  = awaddr;
   assign bus1.awvalid = awvalid;
   assign bus1.wdata   = wdata;
   assign bus1.wstrb   = wstrb;
   assign bus1.wvalid  = wvalid;
   assign bus1.bready  = bready;

   axi4_lite_write_slave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE0), .SIZE_BYTES(SIZE0)
   ) dut0 (
      .clk(clk), .rst(rst), .s_axi(bus0),
      .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_wstrb(mem_wstrb0)
   );

   axi4_lite_write_slave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE1), .SIZE_BYTES(SIZE1)
   ) dut1 (
      .clk(clk), .rst(rst), .s_axi(bus1),
      .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wstrb(mem_wstrb1)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a stuck simulation.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: is the address inside the window (wide arithmetic, so
   // the top-of-memory window cannot wrap), and what offset should appear.
   function automatic bit inWindow(input logic [31:0] base, input logic [31:0] size,
                                   input logic [31:0] a);
      longint unsigned lo, hi, x;
      lo = longint'(base);
      hi = lo + longint'(size);
      x  = longint'(a);
      return (x >= lo) && (x < hi);
   endfunction

   function automatic logic [31:0] windowOffset(input logic [31:0] base, input logic [31:0] a);
      return (a - base) & 32'hFFFF_FFFC;
   endfunction

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Readies and BVALID of both slaves against one expected pattern.
   task automatic checkChannels(input string ph, input bit expAw, input bit expW, input bit expB);
      checkOutput({ph, "/awready0"}, bus0.awready, expAw);
      checkOutput({ph, "/wready0"},  bus0.wready,  expW);
      checkOutput({ph, "/bvalid0"},  bus0.bvalid,  expB);
      checkOutput({ph, "/awready1"}, bus1.awready, expAw);
      checkOutput({ph, "/wready1"},  bus1.wready,  expW);
      checkOutput({ph, "/bvalid1"},  bus1.bvalid,  expB);
   endtask

   task automatic checkNoWrite(input string ph);
      checkOutput({ph, "/mem_we0"}, mem_we0, 1'b0);
      checkOutput({ph, "/mem_we1"}, mem_we1, 1'b0);
   endtask

   task automatic checkResetOutputs(input string ph);
      checkChannels(ph, 1'b0, 1'b0, 1'b0);
      checkOutput({ph, "/bresp0"},     bus0.bresp, 2'b00);
      checkOutput({ph, "/bresp1"},     bus1.bresp, 2'b00);
      checkNoWrite(ph);
      checkOutput({ph, "/mem_addr0"},  mem_addr0,  32'h0);
      checkOutput({ph, "/mem_wdata0"}, mem_wdata0, 32'h0);
      checkOutput({ph, "/mem_wstrb0"}, mem_wstrb0, 4'h0);
      checkOutput({ph, "/mem_addr1"},  mem_addr1,  32'h0);
      checkOutput({ph, "/mem_wdata1"}, mem_wdata1, 32'h0);
      checkOutput({ph, "/mem_wstrb1"}, mem_wstrb1, 4'h0);
   endtask

   // One full write: AW offered after awDelay cycles, W after wDelay cycles,
   // BREADY withheld for bDelay cycles (optionally with fresh AW/W offered
   // meanwhile, which must be ignored). Starts and ends at a falling edge.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input int awDelay,
                                input int wDelay, input int bDelay, input bit pokeBus);
      bit awDone, wDone, hit0, hit1;
      int cyc;
      awDone = 1'b0;
      wDone  = 1'b0;
      cyc    = 0;
      hit0   = inWindow(BASE0, SIZE0, addr);
      hit1   = inWindow(BASE1, SIZE1, addr);

      while (!(awDone && wDone)) begin
         checkChannels("collect", !awDone, !wDone, 1'b0);
         checkNoWrite("collect");
         awvalid = !awDone && (cyc >= awDelay);
         wvalid  = !wDone  && (cyc >= wDelay);
         awaddr  = awvalid ? addr : $urandom;
         wdata   = wvalid  ? data : $urandom;
         wstrb   = wvalid  ? strb : 4'($urandom);
         bready  = 1'($urandom_range(0, 1));
         @(posedge clk);
         if (awvalid) awDone = 1'b1;
         if (wvalid)  wDone  = 1'b1;
         @(negedge clk);
         awvalid = 1'b0;
         wvalid  = 1'b0;
         cyc++;
      end

      // WRITE cycle: the memory port pulses only for an in-window address.
      checkChannels("write", 1'b0, 1'b0, 1'b0);
      checkOutput("write/mem_we0", mem_we0, hit0);
      checkOutput("write/mem_we1", mem_we1, hit1);
      if (hit0) begin
         checkOutput("write/mem_addr0",  mem_addr0,  windowOffset(BASE0, addr));
         checkOutput("write/mem_wdata0", mem_wdata0, data);
         checkOutput("write/mem_wstrb0", mem_wstrb0, strb);
      end
      if (hit1) begin
         checkOutput("write/mem_addr1",  mem_addr1,  windowOffset(BASE1, addr));
         checkOutput("write/mem_wdata1", mem_wdata1, data);
         checkOutput("write/mem_wstrb1", mem_wstrb1, strb);
      end
      bready = 1'($urandom_range(0, 1));
      @(negedge clk);

      // RESP: response held until BREADY, nothing new accepted.
      checkChannels("resp", 1'b0, 1'b0, 1'b1);
      checkNoWrite("resp");
      checkOutput("resp/bresp0", bus0.bresp, hit0 ? 2'b00 : 2'b10);
      checkOutput("resp/bresp1", bus1.bresp, hit1 ? 2'b00 : 2'b10);
      for (int k = 0; k < bDelay; k++) begin
         bready  = 1'b0;
         awvalid = pokeBus;
         wvalid  = pokeBus;
         awaddr  = $urandom;
         wdata   = $urandom;
         wstrb   = 4'($urandom);
         @(negedge clk);
         checkChannels("stall", 1'b0, 1'b0, 1'b1);
         checkNoWrite("stall");
         checkOutput("stall/bresp0", bus0.bresp, hit0 ? 2'b00 : 2'b10);
         checkOutput("stall/bresp1", bus1.bresp, hit1 ? 2'b00 : 2'b10);
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      bready  = 1'b1;
      @(negedge clk);
      checkChannels("done", 1'b1, 1'b1, 1'b0);
      checkNoWrite("done");
      bready = 1'b0;
   endtask

   // Start a write with BREADY low, then assert reset either during the
   // WRITE cycle or during RESP; everything must clear at once.
   task automatic resetDuring(input bit inResp);
      awaddr  = 32'h0000_1004;
      wdata   = 32'hA5A5_5A5A;
      wstrb   = 4'hF;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      bready  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      checkOutput("prereset/mem_we0", mem_we0, 1'b1);
      if (inResp) begin
         @(negedge clk);
         checkOutput("prereset/bvalid0", bus0.bvalid, 1'b1);
      end
      #2 rst = 1'b0;
      #1;
      checkResetOutputs(inResp ? "rst_in_resp" : "rst_in_write");
      @(negedge clk);
      checkResetOutputs("rst_held");
      rst = 1'b1;
      @(negedge clk);
      checkChannels("rst_release", 1'b1, 1'b1, 1'b0);
      checkNoWrite("rst_release");
   endtask

   initial begin
      logic [31:0] a;
      int          sel;

      rst     = 1'b0;
      awaddr  = '0;
      awvalid = 1'b0;
      wdata   = '0;
      wstrb   = '0;
      wvalid  = 1'b0;
      bready  = 1'b0;

      // Power-up reset for two cycles, then release.
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetOutputs("reset");
      rst = 1'b1;
      #1;
      checkChannels("release", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checkChannels("first_edge", 1'b1, 1'b1, 1'b0);

      // Directed cases.
      applyStimulus(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 1'b0);
      applyStimulus(32'h0000_2000, 32'hCAFE_BABE, 4'h3, 0, 3, 0, 1'b0);
      applyStimulus(32'h0000_3FFC, 32'h1234_5678, 4'hF, 2, 0, 0, 1'b0);
      applyStimulus(32'h0000_4000, 32'h0BAD_0BAD, 4'hF, 0, 0, 0, 1'b0);
      applyStimulus(32'hFFFF_FFFC, 32'h7777_8888, 4'hC, 1, 1, 0, 1'b0);
      applyStimulus(32'hFFFF_F000, 32'h1111_2222, 4'h5, 0, 1, 0, 1'b0);
      applyStimulus(32'h0000_1003, 32'h5555_AAAA, 4'h0, 0, 0, 5, 1'b1);

      // Reset in the middle of a write, then a normal write afterwards.
      resetDuring(1'b1);
      applyStimulus(32'h0000_0010, 32'h0F0F_F0F0, 4'h9, 0, 0, 0, 1'b0);
      resetDuring(1'b0);
      applyStimulus(32'h0000_0020, 32'hF00D_FACE, 4'hF, 1, 0, 1, 1'b0);

      // Randomized traffic clustered around both window boundaries.
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 4);
         case (sel)
            0:       a = 32'($urandom_range(0, 32'h0000_4100));
            1:       a = 32'h0000_3FF0 + 32'($urandom_range(0, 31));
            2:       a = 32'hFFFF_EFF0 + 32'($urandom_range(0, 31));
            3:       a = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
            default: a = $urandom;
         endcase
         applyStimulus(a, $urandom, 4'($urandom), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/axi4_lite_write_slave.md
# axi4_lite_write_slave

AXI4-Lite write-channel slave that sits directly downstream of `axi4_lite_write_master`. It accepts the AW and W channels independently and in either order, range-checks the address, and issues one single-cycle write on a simple memory/peripheral write port. It then returns a B response. It is the write-side endpoint in front of data memory and memory-mapped peripherals on the SoC interconnect.

## Interface
- ADDR_WIDTH, 32, AXI address and mem_addr width
- DATA_WIDTH, 32, data width; STRB_WIDTH = DATA_WIDTH/8 (derived, not overridable)
- BASE_ADDR, 32'h0000_0000, first byte address decoded by this slave
- SIZE_BYTES, 32'h0000_4000, size of the decoded window in bytes

Ports:
- clk  input  1  clock; all flops rise-edge
- rst  input  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low)
- S_AXI_AWADDR  input  ADDR_WIDTH  write address
- S_AXI_AWVALID  input  1  address valid
- S_AXI_AWREADY  output  1  address ready (registered)
- S_AXI_WDATA  input  DATA_WIDTH  write data
- S_AXI_WSTRB  input  STRB_WIDTH  byte strobes
- S_AXI_WVALID  input  1  data valid
- S_AXI_WREADY  output  1  data ready (registered)
- S_AXI_BRESP  output  2  response: 2'b00 OKAY, 2'b10 SLVERR
- S_AXI_BVALID  output  1  response valid
- S_AXI_BREADY  input  1  response ready
- mem_we  output  1  one-cycle write enable
- mem_addr  output  ADDR_WIDTH  word-aligned byte offset: (AWADDR - BASE_ADDR) with bits [1:0] forced to 0
- mem_wdata  output  DATA_WIDTH  captured WDATA
- mem_wstrb  output  STRB_WIDTH  captured WSTRB

## Operation
- States: COLLECT, WRITE, RESP. Reset state is COLLECT, with both capture flags (aw_full, w_full) cleared.
- COLLECT:
  - AWREADY = 1 while !aw_full; WREADY = 1 while !w_full.
  - An AW handshake captures AWADDR and sets aw_full. A W handshake captures WDATA/WSTRB and sets w_full.
  - Both handshakes may occur on the same edge.
  - The ready for a channel drops on the edge where that channel's handshake occurs.
  - When both flags are set after an edge (including simultaneous capture), the next state is WRITE.
- WRITE (exactly one cycle):
  - If BASE_ADDR <= addr < BASE_ADDR+SIZE_BYTES: mem_we = 1, mem_* driven from captures, resp = OKAY.
  - Otherwise mem_we = 0 and resp = SLVERR.
  - The comparison uses ADDR_WIDTH+1-bit arithmetic so BASE_ADDR+SIZE_BYTES cannot wrap.
  - WSTRB = 0 in range still pulses mem_we with mem_wstrb = 0 and responds OKAY.
- RESP:
  - BVALID = 1 and BRESP = the latched resp; both are held stable until BREADY.
  - On the BVALID && BREADY edge: BVALID goes to 0, flags clear, state becomes COLLECT, and AWREADY/WREADY become 1 on that same edge.
- AWREADY = WREADY = 0 in WRITE and RESP. A new AW/W is never accepted before the B handshake, so there is one outstanding write.
- AWADDR[1:0] is ignored (no misalignment error).

## Timing
- Reset values (while rst = 0), applied asynchronously:
  - AWREADY 0, WREADY 0, BVALID 0, BRESP 2'b00, mem_we 0.
  - mem_addr, mem_wdata and mem_wstrb are all 0.
- AWREADY/WREADY rise on the first clk edge after rst deasserts.
- Latency, with the last of AW/W captured at edge E:
  - mem_we high for exactly the cycle E..E+1.
  - BVALID high from edge E+1.
  - With BREADY held high, BVALID falls and readies rise at E+2.
  - Minimum 3 cycles per write.
- BREADY low: BVALID, BRESP and the readies (0) are held indefinitely.
- AWVALID/WVALID dropping before their ready (AXI violation): nothing is captured, no error is raised.
- Reset asserted mid-transaction (WRITE or RESP):
  - All outputs go to their reset values immediately and the captured transaction is discarded.
  - No mem_we pulse occurs after reset is asserted.

## Test plan
- Reset: hold rst = 0 for 2 cycles → all outputs 0. Release → AWREADY = WREADY = 1 after the first edge.
- Simultaneous AW/W: AWADDR 0x0000_1000, WDATA 0xDEAD_BEEF, WSTRB 4'b1111, BREADY = 1 → one mem_we pulse with mem_addr 0x1000, mem_wdata 0xDEADBEEF, mem_wstrb 4'hF, the cycle after the handshake. BVALID one cycle later with BRESP 00. Readies are back to 1 after the B handshake.
- AW first, W 3 cycles later: AWADDR 0x2000, then WDATA 0xCAFEBABE, WSTRB 4'b0011 → AWREADY 0 from the AW edge while WREADY stays 1. mem_we pulses only after W, with mem_wstrb 4'b0011. BRESP 00.
- W first, AW 2 cycles later: AWADDR 0x3FFC, WDATA 0x1234_5678 → WREADY drops first. mem_addr 0x3FFC, BRESP 00.
- Out of range and wrap: AWADDR 0x4000 → mem_we never asserted, BRESP 10. Repeat with BASE_ADDR 0xFFFF_F000, SIZE_BYTES 0x1000, AWADDR 0xFFFF_FFFC → in range, OKAY.
- Back-pressure and reset:
  - Hold BREADY = 0 for 5 cycles → BVALID/BRESP stable and readies 0 throughout; a new AWVALID is not accepted.
  - Assert rst during RESP → BVALID 0 immediately. After release, a fresh write completes normally.
